// File: rtl/porta_pad_coleco_pkg.sv
// -----------------------------------------------------------------------------
// porta_pad_coleco_pkg
// Shared constants for the Coleco controller front-end:
//   - bit positions inside one 18-bit pad chain (raw 0 = pressed)
//   - keypad nibble table indexed by key number (0..9, '*', '#')
//   - scan FSM state encoding
// -----------------------------------------------------------------------------
package porta_pad_coleco_pkg;

  localparam int PAD_BITS  = 18;
  localparam int NUM_PADS  = 2;

  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_LFIRE = 4;
  localparam int BIT_RFIRE = 5;
  localparam int BIT_KEY0  = 6;
  localparam int BIT_STAR  = 16;
  localparam int BIT_HASH  = 17;

  localparam int NUM_KEYS  = BIT_HASH - BIT_KEY0 + 1;

  // Nibble the Coleco keypad matrix presents for each key, entry k = key k
  // for k=0..9, then '*', then '#'.
  localparam logic [3:0] KEY_NIBBLE [NUM_KEYS] = '{
    4'hA, 4'hD, 4'h7, 4'hC, 4'h2, 4'h3, 4'hE, 4'h5, 4'h1, 4'hB,
    4'h9, 4'h6
  };

  // Gray-coded so every transition of the scan sequence
  // (LOAD->LOW->HIGH->LOW...->HIGH->COMMIT->LOAD) flips a single bit; the
  // chain control lines are decoded straight from these bits.
  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_LOW    = 2'b01,
    ST_HIGH   = 2'b11,
    ST_COMMIT = 2'b10
  } scan_state_e;

endpackage

// File: rtl/porta_pad_debounce.sv
// -----------------------------------------------------------------------------
// porta_pad_debounce
// N-bit vector debouncer. Each bit owns a small counter that advances on
// every enable strobe while the raw bit disagrees with the debounced bit;
// after DEBOUNCE_SCANS consecutive disagreeing strobes the debounced bit
// takes the raw value. Any agreeing strobe clears the counter.
// Ports:
//   clk      system clock
//   rstn     asynchronous active-low reset (debounced bits -> 1, released)
//   en_i     one-cycle update strobe (end of a scan)
//   raw_i    raw sampled vector
//   deb_o    debounced vector
// -----------------------------------------------------------------------------
module porta_pad_debounce #(
  parameter int WIDTH          = 36,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_q, cnt_d;
      logic          deb_q, deb_d;

      always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (en_i) begin
          if (raw_i[gi] == deb_q) begin
            cnt_d = '0;
          end else if (cnt_q == CW'(DEBOUNCE_SCANS - 1)) begin
            // this strobe is the DEBOUNCE_SCANS-th disagreement
            deb_d = raw_i[gi];
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          cnt_q <= '0;
          deb_q <= 1'b1;
        end else begin
          cnt_q <= cnt_d;
          deb_q <= deb_d;
        end
      end

      assign deb_o[gi] = deb_q;
    end
  endgenerate

endmodule

// File: rtl/porta_pad_coleco.sv
// -----------------------------------------------------------------------------
// porta_pad_coleco
// Scans two 74HC165-style button chains, debounces all 36 buttons and
// re-encodes them into active-low Coleco controller lines, selected by the
// joystick/keypad strobes driven back by the glue logic.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   SR_LOADn, SR_CLK     chain parallel-load (active low) and shift clock
//   SR_DATA1, SR_DATA2   serial data from player 1 / player 2 chain
//   C4_ARM, C7_FIRE      keypad / joystick select, active low
//   C1P*, C2P*           player 1 / player 2 Coleco lines, active low
// -----------------------------------------------------------------------------
module porta_pad_coleco
  import porta_pad_coleco_pkg::*;
#(
  parameter int CLK_DIV        = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic clk,
  input  logic rstn,
  output logic SR_LOADn,
  output logic SR_CLK,
  input  logic SR_DATA1,
  input  logic SR_DATA2,
  input  logic C4_ARM,
  input  logic C7_FIRE,
  output logic C1P0, C1P1, C1P2, C1P3, C1P5, C1P6,
  output logic C2P0, C2P1, C2P2, C2P3, C2P5, C2P6
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(PAD_BITS);

  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  scan_state_e         state_q, state_d;
  logic                run_q, run_d;
  logic [PAD_BITS-1:0] raw1_q, raw1_d, raw2_q, raw2_d;
  logic                tick;
  logic                commit;

  assign tick = (div_q == DW'(CLK_DIV - 1));

  // run_q holds the chain idle for the first tick after reset, so the scan
  // starts cleanly at LOAD on that tick with SR_LOADn high during reset.
  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    run_d   = run_q;
    raw1_d  = raw1_q;
    raw2_d  = raw2_q;
    if (tick) begin
      if (!run_q) begin
        run_d = 1'b1;
      end else begin
        unique case (state_q)
          ST_LOAD: state_d = ST_LOW;
          ST_LOW: begin
            // last clk of the LOW tick: chain output is stable here
            raw1_d[idx_q] = SR_DATA1;
            raw2_d[idx_q] = SR_DATA2;
            state_d       = ST_HIGH;
          end
          ST_HIGH: begin
            if (idx_q == IW'(PAD_BITS - 1)) begin
              idx_d   = '0;
              state_d = ST_COMMIT;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = ST_LOW;
            end
          end
          ST_COMMIT: state_d = ST_LOAD;
          default:   state_d = ST_LOAD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q   <= '0;
      idx_q   <= '0;
      state_q <= ST_LOAD;
      run_q   <= 1'b0;
      raw1_q  <= '1;
      raw2_q  <= '1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      run_q   <= run_d;
      raw1_q  <= raw1_d;
      raw2_q  <= raw2_d;
    end
  end

  assign SR_LOADn = !(run_q && (state_q == ST_LOAD));
  assign SR_CLK   = run_q && (state_q == ST_HIGH);
  assign commit   = tick && run_q && (state_q == ST_COMMIT);

  logic [NUM_PADS*PAD_BITS-1:0] deb;

  porta_pad_debounce #(
    .WIDTH          (NUM_PADS * PAD_BITS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk   (clk),
    .rstn  (rstn),
    .en_i  (commit),
    .raw_i ({raw2_q, raw1_q}),
    .deb_o (deb)
  );

  // Mode decode is purely combinational: the CPU reads right after writing
  // the select, so no register may sit in this path. Joystick wins if both
  // selects are low.
  logic joy_mode, key_mode;
  assign joy_mode = !C7_FIRE;
  assign key_mode = C7_FIRE && !C4_ARM;

  // per pad: {P6, P5, P3, P2, P1, P0}
  logic [5:0] pad_out [NUM_PADS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [PAD_BITS-1:0] pad;
      logic [3:0]          nib;

      assign pad = deb[gi*PAD_BITS +: PAD_BITS];

      // scan from the top down so the lowest-index pressed key wins
      always_comb begin
        nib = 4'hF;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
          if (!pad[BIT_KEY0 + k]) nib = KEY_NIBBLE[k];
        end
      end

      always_comb begin
        pad_out[gi] = 6'h3F;
        if (joy_mode) begin
          pad_out[gi] = {1'b1, pad[BIT_LFIRE], pad[BIT_RIGHT],
                         pad[BIT_LEFT], pad[BIT_DOWN], pad[BIT_UP]};
        end else if (key_mode) begin
          pad_out[gi] = {1'b1, pad[BIT_RFIRE], nib[1], nib[3], nib[2], nib[0]};
        end
      end
    end
  endgenerate

  assign {C1P6, C1P5, C1P3, C1P2, C1P1, C1P0} = pad_out[0];
  assign {C2P6, C2P5, C2P3, C2P2, C2P1, C2P0} = pad_out[1];

endmodule

// File: tb/tb_porta_pad_coleco.sv
// -----------------------------------------------------------------------------
// tb_porta_pad_coleco
// Self-checking bench: behavioural 74HC165 chain models feed the DUT; a
// vector table covers the encodings, hand sequences cover debounce timing,
// glitch rejection, scan timing and asynchronous reset mid-scan.
// -----------------------------------------------------------------------------
module tb_porta_pad_coleco;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic SR_LOADn, SR_CLK, SR_DATA1, SR_DATA2;
  logic C4_ARM = 1'b1;
  logic C7_FIRE = 1'b0;
  logic C1P0, C1P1, C1P2, C1P3, C1P5, C1P6;
  logic C2P0, C2P1, C2P2, C2P3, C2P5, C2P6;

  always #5 clk = ~clk;

  porta_pad_coleco #(.CLK_DIV(16), .DEBOUNCE_SCANS(3)) dut (
    .clk(clk), .rstn(rstn),
    .SR_LOADn(SR_LOADn), .SR_CLK(SR_CLK),
    .SR_DATA1(SR_DATA1), .SR_DATA2(SR_DATA2),
    .C4_ARM(C4_ARM), .C7_FIRE(C7_FIRE),
    .C1P0(C1P0), .C1P1(C1P1), .C1P2(C1P2), .C1P3(C1P3), .C1P5(C1P5), .C1P6(C1P6),
    .C2P0(C2P0), .C2P1(C2P1), .C2P2(C2P2), .C2P3(C2P3), .C2P5(C2P5), .C2P6(C2P6)
  );

  // chain models: bit 0 on the serial output after load, shift on SR_CLK rise
  logic [17:0] pad1 = '1;
  logic [17:0] pad2 = '1;
  logic [17:0] sh1 = '1;
  logic [17:0] sh2 = '1;
  logic        sclk_prev = 1'b0;

  always @(posedge clk) begin
    if (!SR_LOADn) begin
      sh1 <= pad1;
      sh2 <= pad2;
    end else if (SR_CLK && !sclk_prev) begin
      sh1 <= {1'b1, sh1[17:1]};
      sh2 <= {1'b1, sh2[17:1]};
    end
    sclk_prev <= SR_CLK;
  end
  assign SR_DATA1 = sh1[0];
  assign SR_DATA2 = sh2[0];

  wire [5:0] out1 = {C1P6, C1P5, C1P3, C1P2, C1P1, C1P0};
  wire [5:0] out2 = {C2P6, C2P5, C2P3, C2P2, C2P1, C2P0};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // wait (bounded) for SR_LOADn to change to the given level
  task automatic wait_loadn(input logic level);
    logic prev;
    bit   ok;
    ok   = 1'b0;
    prev = SR_LOADn;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (SR_LOADn == level && prev != level) begin
        ok = 1'b1;
        break;
      end
      prev = SR_LOADn;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL loadn_wait timeout actual=%b required_edge_to=%b", SR_LOADn, level);
    end
  endtask

  task automatic wait_falls(input int n);
    for (int k = 0; k < n; k++) wait_loadn(1'b0);
  endtask

  // bounded count of negedges until SR_LOADn goes low
  task automatic clocks_to_load(output int n);
    n = 0;
    for (int t = 1; t <= 2000; t++) begin
      @(negedge clk);
      if (!SR_LOADn) begin
        n = t;
        break;
      end
    end
  endtask

  typedef struct {
    string       name;
    logic [17:0] p1;
    logic [17:0] p2;
    logic        c4;
    logic        c7;
    logic [5:0]  e1;  // {P6,P5,P3,P2,P1,P0}
    logic [5:0]  e2;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n, lows, rises, cyc;
    logic prevc, prevl;
    logic [17:0] last1, last2;

    // ---------------- reset state ----------------
    repeat (4) @(negedge clk);
    check("rst_loadn", SR_LOADn, 1'b1);
    check("rst_sclk", SR_CLK, 1'b0);
    check("rst_out1", out1, 6'h3F);
    check("rst_out2", out2, 6'h3F);
    C4_ARM = 1'b0; C7_FIRE = 1'b1;
    #1;
    check("rst_kp_out1", out1, 6'h3F);
    C4_ARM = 1'b1; C7_FIRE = 1'b0;

    rstn = 1'b1;
    clocks_to_load(n);
    check("first_load_delay", n, 16);

    // ---------------- scan period timing ----------------
    lows = 1; rises = 0; cyc = 0;
    prevc = SR_CLK; prevl = SR_LOADn;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      cyc++;
      if (!SR_LOADn && prevl) break;
      if (!SR_LOADn) lows++;
      if (SR_CLK && !prevc) rises++;
      prevc = SR_CLK;
      prevl = SR_LOADn;
    end
    check("scan_period", cyc, 608);
    check("load_low_clks", lows, 16);
    check("sclk_pulses", rises, 18);
    check("idle_out1", out1, 6'h3F);
    check("idle_out2", out2, 6'h3F);

    // ---------------- up press / release timing ----------------
    wait_loadn(1'b1);
    pad1 = ~18'h1;
    wait_falls(3);
    check("up_after2", out1, 6'h3F);
    wait_falls(1);
    check("up_after3", out1, 6'b111110);
    check("up_p2", out2, 6'h3F);
    wait_loadn(1'b1);
    pad1 = '1;
    wait_falls(3);
    check("uprel_after2", out1, 6'b111110);
    wait_falls(1);
    check("uprel_after3", out1, 6'h3F);

    // ---------------- 2-scan right-fire glitch (keypad) ----------------
    C4_ARM = 1'b0; C7_FIRE = 1'b1;
    wait_loadn(1'b1);
    pad1 = ~(18'h1 << 5);
    wait_falls(2);
    wait_loadn(1'b1);
    pad1 = '1;
    wait_falls(2);
    check("glitch_a", C1P5, 1'b1);
    wait_falls(2);
    check("glitch_b", C1P5, 1'b1);

    // ---------------- reset mid-scan with left fire held ----------------
    C4_ARM = 1'b1; C7_FIRE = 1'b0;
    wait_loadn(1'b1);
    pad1 = ~(18'h1 << 4);
    wait_falls(5);
    check("lf_held", out1, 6'b101111);
    wait_loadn(1'b1);
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midrst_out1", out1, 6'h3F);
    check("midrst_loadn", SR_LOADn, 1'b1);
    check("midrst_sclk", SR_CLK, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    clocks_to_load(n);
    check("midrst_load_delay", n, 16);
    wait_falls(2);
    check("lf_after2", out1, 6'h3F);
    wait_falls(1);
    check("lf_after3", out1, 6'b101111);

    // ---------------- encoding table ----------------
    vecs[0]  = '{"joy_up",      ~18'h1,                         '1, 1'b1, 1'b0, 6'b111110, 6'b111111};
    vecs[1]  = '{"kp_p2_key5",  '1,            ~(18'h1 << 11),      1'b0, 1'b1, 6'b111111, 6'b111001};
    vecs[2]  = '{"sw_joy_key5", '1,            ~(18'h1 << 11),      1'b0, 1'b0, 6'b111111, 6'b111111};
    vecs[3]  = '{"kp_1_hash",   ~((18'h1 << 7) | (18'h1 << 17)), '1, 1'b0, 1'b1, 6'b110111, 6'b111111};
    vecs[4]  = '{"kp_hash",     ~(18'h1 << 17),                 '1, 1'b0, 1'b1, 6'b111010, 6'b111111};
    vecs[5]  = '{"both_low_up", ~18'h61,                        '1, 1'b0, 1'b0, 6'b111110, 6'b111111};
    vecs[6]  = '{"kp_0_rfire",  ~18'h61,                        '1, 1'b0, 1'b1, 6'b101100, 6'b111111};
    vecs[7]  = '{"both_high",   ~18'h61,                        '1, 1'b1, 1'b1, 6'b111111, 6'b111111};
    vecs[8]  = '{"joy_p2_dirs", '1,            ~18'h1E,             1'b1, 1'b0, 6'b111111, 6'b100001};
    vecs[9]  = '{"kp_4_9star",  ~(18'h1 << 10), ~((18'h1 << 15) | (18'h1 << 16)), 1'b0, 1'b1, 6'b111000, 6'b111101};
    vecs[10] = '{"kp_3_8",      ~(18'h1 << 9),  ~(18'h1 << 14),     1'b0, 1'b1, 6'b110110, 6'b110001};
    vecs[11] = '{"kp_6_2",      ~(18'h1 << 12), ~(18'h1 << 8),      1'b0, 1'b1, 6'b111110, 6'b111011};
    vecs[12] = '{"kp_7",        ~(18'h1 << 13), '1,                 1'b0, 1'b1, 6'b110011, 6'b111111};

    last1 = pad1;
    last2 = pad2;
    for (int i = 0; i < 13; i++) begin
      if (i == 0 || vecs[i].p1 != last1 || vecs[i].p2 != last2) begin
        pad1 = vecs[i].p1;
        pad2 = vecs[i].p2;
        last1 = vecs[i].p1;
        last2 = vecs[i].p2;
        wait_falls(5);
      end
      C4_ARM  = vecs[i].c4;
      C7_FIRE = vecs[i].c7;
      #1;
      check({vecs[i].name, "_p1"}, out1, vecs[i].e1);
      check({vecs[i].name, "_p2"}, out2, vecs[i].e2);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
